// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//  - UART_BASE:  default MMIO window base (16-byte window)
//  - OFF_*:      register offsets, taken from addr[3:2]
//  - STATUS_*:   bit positions inside the STATUS register
//  - uart_tx_state_e: serialiser FSM states
package mmio_pkg;

    localparam logic [31:0] UART_BASE = 32'h0000_4000;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int unsigned STATUS_EMPTY = 0;
    localparam int unsigned STATUS_FULL  = 1;
    localparam int unsigned STATUS_BUSY  = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
//  clk_i    in   clock, rising edge
//  rst_i    in   synchronous active-high reset, empties the FIFO
//  push_i   in   write wdata_i (ignored when full)
//  wdata_i  in   write data
//  pop_i    in   drop the head entry (ignored when empty)
//  rdata_o  out  head entry, valid whenever empty_o is low
//  full_o   out  level == DEPTH
//  empty_o  out  level == 0
//  level_o  out  number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; contents are only visible through level_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory port.
//  clk_i / rst_i          clock, synchronous active-high reset
//  dmem_rd_i, dmem_wr_i   core read / write request
//  dmem_strobe_i          byte-lane write enables
//  dmem_addr_i            byte address; window hit when addr[31:4] == BASE_ADDR[31:4]
//  dmem_wdata_i           write data
//  dmem_ready_o           low only for a TXDATA push while the FIFO is full
//  dmem_rdata_o           read data, one cycle after the accepted read
//  dmem_rdata_valid_o     read-data strobe
//  sel_o                  combinational window hit
//  tx_o                   serial line, idle high
//  busy_o                 frame in progress or FIFO not empty
// Registers (addr[3:2]): 0 TXDATA (W), 1 STATUS (R: busy/full/empty), 2 BAUD (R/W), 3 reserved.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = UART_BASE,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_rd_i,
    input  logic        dmem_wr_i,
    input  logic [3:0]  dmem_strobe_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_ready_o,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_rdata_valid_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          wr_txdata, wr_baud, rd_accept, push, pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic [15:0]   baud_q, baud_d, baud_merged;
    logic [31:0]   rd_value;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    uart_tx_state_e state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           bit_end;

    logic unused_bits;
    assign unused_bits = ^{dmem_addr_i[1:0], dmem_wdata_i[31:16], dmem_strobe_i[3:2], fifo_level};

    // ---------------- decode ----------------
    assign off       = dmem_addr_i[3:2];
    assign sel_o     = (dmem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata = sel_o & dmem_wr_i & (off == OFF_TXDATA) & dmem_strobe_i[0];
    assign wr_baud   = sel_o & dmem_wr_i & (off == OFF_BAUD);

    assign dmem_ready_o = ~(wr_txdata & fifo_full);
    assign push         = wr_txdata & ~fifo_full;
    assign rd_accept    = sel_o & dmem_rd_i & dmem_ready_o;

    assign busy_o = (state_q != TX_IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (dmem_wdata_i[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // ---------------- register file / read pipeline ----------------
    always_comb begin
        baud_d      = baud_q;
        baud_merged = baud_q;
        if (dmem_strobe_i[0]) begin
            baud_merged[7:0] = dmem_wdata_i[7:0];
        end
        if (dmem_strobe_i[1]) begin
            baud_merged[15:8] = dmem_wdata_i[15:8];
        end
        // A zero divider would never end a bit period.
        if (wr_baud) begin
            baud_d = (baud_merged == '0) ? 16'd1 : baud_merged;
        end
    end

    always_comb begin
        rd_value = '0;
        case (off)
            OFF_STATUS: begin
                rd_value[STATUS_EMPTY] = fifo_empty;
                rd_value[STATUS_FULL]  = fifo_full;
                rd_value[STATUS_BUSY]  = busy_o;
            end
            OFF_BAUD: rd_value[15:0] = baud_q;
            default:  rd_value = '0;
        endcase
        rdata_d  = rd_accept ? rd_value : '0;
        rvalid_d = rd_accept;
    end

    assign dmem_rdata_o       = rdata_q;
    assign dmem_rdata_valid_o = rvalid_q;

    // ---------------- serialiser ----------------
    // cnt_q counts down the remaining cycles of the current bit; BAUD is
    // sampled only when a bit starts, so mid-frame writes never stretch a bit.
    assign bit_end = (cnt_q == '0);
    assign tx_o    = tx_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    tx_d    = 1'b0;
                    cnt_d   = baud_q - 16'd1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shreg_q[0];
                    cnt_d     = baud_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = baud_q - 16'd1;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        tx_d    = 1'b0;
                        cnt_d   = baud_q - 16'd1;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_q    <= DEFAULT_DIV;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            baud_q    <= baud_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX     = 32'h0000_4000;
    localparam logic [31:0] A_STATUS = 32'h0000_4004;
    localparam logic [31:0] A_BAUD   = 32'h0000_4008;
    localparam logic [31:0] A_RSVD   = 32'h0000_400C;
    localparam int          LIMIT    = 3000;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [3:0]  strb;
    logic [31:0] addr, wdata;
    logic        ready, rvalid, sel, tx, busy;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] exp_q [$];
    logic [7:0] t2_bytes [10] = '{8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A,
                                  8'hC3, 8'h01, 8'h80, 8'h7E, 8'h96};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_uart_tx #(
        .BASE_ADDR   (32'h0000_4000),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .dmem_rd_i          (rd),
        .dmem_wr_i          (wr),
        .dmem_strobe_i      (strb),
        .dmem_addr_i        (addr),
        .dmem_wdata_i       (wdata),
        .dmem_ready_o       (ready),
        .dmem_rdata_o       (rdata),
        .dmem_rdata_valid_o (rvalid),
        .sel_o              (sel),
        .tx_o               (tx),
        .busy_o             (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends just after a falling edge; holds the request while ready is low.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int stall);
        int n = 0;
        wr = 1'b1; addr = a; wdata = d; strb = s;
        while (ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("write_ready_timeout", ready, 1'b1);
        @(negedge clk);
        wr = 1'b0; strb = 4'h0;
        stall = n;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Receives one frame sampling mid-bit; start returns the cycle of the first low sample.
    task automatic rx_frame(input int div, output logic [7:0] b, output int start);
        int n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        start = cyc;
        if (n >= LIMIT) begin
            check("rx_start_timeout", tx, 1'b0);
            return;
        end
        repeat (div / 2) @(negedge clk);
        check("rx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = tx;
        end
        repeat (div) @(negedge clk);
        check("rx_stop_bit", tx, 1'b1);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        int          stall;
        int          stalls [10];
        logic [9:0]  fr;
        logic [3:0]  vec;
        logic [63:0] wave, wave_exp;
        int          idx, lows;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; strb = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", ready, 1'b1);
        check("rst_sel_outside", sel, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Register reads
        bus_read(A_STATUS, d, v);
        check("status_after_reset", d, 32'h1);
        check("status_valid", v, 1'b1);
        @(negedge clk);
        check("rvalid_drops", rvalid, 1'b0);
        check("rdata_zero_idle", rdata, 32'h0);
        bus_read(A_BAUD, d, v);
        check("baud_default", d, 32'd868);
        bus_write(A_BAUD, 32'h0, 4'h3, stall);
        bus_read(A_BAUD, d, v);
        check("baud_zero_as_one", d, 32'h1);
        bus_read(A_RSVD, d, v);
        check("rsvd_reads_zero", d, 32'h0);
        check("rsvd_valid", v, 1'b1);
        bus_read(A_TX, d, v);
        check("txdata_reads_zero", d, 32'h0);
        bus_write(A_BAUD, 32'hFFFF_0004, 4'h3, stall);
        bus_read(A_BAUD, d, v);
        check("baud_four", d, 32'h4);
        bus_read(32'h0000_3FFC, d, v);
        check("miss_read_no_valid", v, 1'b0);

        // Single frame 0xA5 at DIV=4
        bus_write(A_TX, 32'h0000_00A5, 4'h1, stall);
        check("t1_tx_high_at_push", tx, 1'b1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                vec[j] = tx;
            end
            check($sformatf("t1_bit%0d", b), vec, {4{fr[b]}});
        end
        @(negedge clk);
        check("t1_idle_after", tx, 1'b1);
        check("t1_not_busy", busy, 1'b0);
        wait_idle();

        // Burst of 10 writes: FIFO holds 8, serialiser one; the 10th stalls until a pop
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    exp_q.push_back(t2_bytes[i]);
                    bus_write(A_TX, {24'h0, t2_bytes[i]}, 4'h1, stalls[i]);
                end
            end
            begin
                logic [7:0] rb;
                int st, prev;
                prev = 0;
                for (int i = 0; i < 10; i++) begin
                    rx_frame(4, rb, st);
                    if (exp_q.size() == 0) check("sb_empty", 1'b1, 1'b0);
                    else check($sformatf("t2_frame%0d", i), rb, exp_q.pop_front());
                    if (i > 0) check($sformatf("t2_gap%0d", i), st - prev, 40);
                    prev = st;
                end
            end
        join
        check("t2_ninth_no_stall", stalls[8], 0);
        check("t2_tenth_stall", stalls[9], 33);
        wait_idle();

        // BAUD 4 -> 8 written during data bit 3 of 0x55
        bus_write(A_TX, 32'h0000_0055, 4'h1, stall);
        wave[0] = tx;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            wave[i] = tx;
            if (i == 18) begin
                wr = 1'b1; addr = A_BAUD; wdata = 32'h8; strb = 4'h3;
            end
            if (i == 19) begin
                wr = 1'b0; strb = 4'h0;
            end
        end
        wave_exp = '1;
        idx = 1;
        for (int j = 0; j < 4; j++) wave_exp[idx++] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < ((b < 4) ? 4 : 8); j++) wave_exp[idx++] = b[0] ? 1'b0 : 1'b1;
        end
        check("t4_bit3_four_cycles", {wave[21], wave[20:17], wave[16]}, 6'b100001);
        check("t4_bit4_eight_cycles", {wave[29], wave[28:21]}, 9'h0FF);
        check("t4_waveform", wave, wave_exp);
        wait_idle();
        bus_write(A_BAUD, 32'h4, 4'h1, stall);

        // Out-of-window write and TXDATA write without lane 0
        wr = 1'b1; addr = 32'h0000_3FFC; wdata = 32'h77; strb = 4'hF;
        #1;
        check("t6_miss_ready", ready, 1'b1);
        check("t6_miss_sel", sel, 1'b0);
        @(negedge clk);
        addr = A_TX; wdata = 32'h33; strb = 4'b0010;
        #1;
        check("t6_nolane_ready", ready, 1'b1);
        check("t6_hit_sel", sel, 1'b1);
        @(negedge clk);
        wr = 1'b0; strb = 4'h0;
        @(negedge clk);
        check("t6_not_busy", busy, 1'b0);
        bus_read(A_STATUS, d, v);
        check("t6_status_empty", d, 32'h1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t6_no_frame", lows, 0);

        // Reset mid-frame with 3 bytes queued
        for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h11 * (i + 1), 4'h1, stall);
        repeat (12) @(negedge clk);
        check("t5_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_tx_high", tx, 1'b1);
        check("t5_busy_clear", busy, 1'b0);
        check("t5_rvalid_clear", rvalid, 1'b0);
        rst = 1'b0;
        bus_read(A_STATUS, d, v);
        check("t5_status", d, 32'h1);
        bus_read(A_BAUD, d, v);
        check("t5_baud_default", d, 32'd868);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t5_no_frame", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
